pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
Parametrised next-generation program counter for the fetch stage. It keeps the architectural PC and selects the next fetch address from a priority set of sources: redirect, return, register jump, absolute jump, branch, or sequential. It adds a circular return-address stack (RAS) that pushes link addresses on calls and pops predicted targets on returns. It sits between the control/hazard logic and instruction memory, and replaces the single-width fixed PC.

Parameters:
ADDR_W, 32, PC/address width in bits; must be ≥ JIMM_W+2.
RESET_PC, 32'h0000_0000, PC value on reset, truncated to ADDR_W.
BIMM_W, 16, branch immediate width; sign-extended word offset.
JIMM_W, 26, jump immediate width; word index.
RAS_DEPTH, 8, RAS entries; power of two, ≥2.
BR_REL_NPC, 0, 0 = branch target relative to pcaddr; 1 = relative to pcaddr+4.
JUMP_KEEP_UPPER, 0, 0 = jump upper bits are zero; 1 = upper bits are taken from pcaddr+4.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
advance  in  1  fetch accepted (ihit); PC and RAS update only when advance=1 and stall=0
stall  in  1  hazard hold; overrides advance
redirect  in  1  forced redirect (mispredict/exception); highest priority
redirect_addr  in  ADDR_W  redirect target
Branch  in  1  take branch
bimm  in  BIMM_W  signed branch word offset
Jump  in  1  absolute jump
jimm  in  JIMM_W  jump word index
Link  in  1  call; pushes pcaddr+4 (qualifies Jump or JR)
JR  in  1  register jump
Ret  in  1  qualifies JR as a return; uses RAS prediction
jraddr  in  ADDR_W  register jump target
ras_flush  in  1  empty the RAS
pcaddr  out  ADDR_W  current PC
npc  out  ADDR_W  pcaddr+4, combinational
ras_top  out  ADDR_W  top RAS entry; 0 when empty
ras_count  out  clog2(RAS_DEPTH)+1  valid entries
ras_empty  out  1  ras_count==0
ras_full  out  1  ras_count==RAS_DEPTH
ras_overflow  out  1  sticky; set on a push while full

Behaviour:
- Reset (RST=1, asynchronous, valid at any time, including mid-sequence): pcaddr=RESET_PC, ras_count=0, stack pointer=0, ras_overflow=0, all entries=0.
- Update condition: upd = advance & ~stall. When upd=0, all state holds. redirect/Branch/Jump/etc. are ignored unless upd=1.
- Next-PC priority when upd=1:
  1. redirect → redirect_addr
  2. JR&Ret → ras_top if ~ras_empty, else jraddr
  3. JR → jraddr
  4. Jump → {upper, jimm, 2'b00}, where upper = npc[ADDR_W-1:JIMM_W+2] if JUMP_KEEP_UPPER, else 0
  5. Branch → base + (sext(bimm)<<2), where base = npc if BR_REL_NPC else pcaddr
  6. otherwise → npc
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- RAS operations, only when upd=1 and redirect=0:
  - pop = JR&Ret&~ras_empty
  - push = Link&(Jump|JR)
  - Push writes npc at pointer, then pointer+1 mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry (circular) and sets ras_overflow.
  - Pop: pointer-1, count-1. Pop while empty is a no-op and uses the jraddr fallback.
  - Push and pop together: the top entry is replaced with npc; pointer and count are unchanged.
- ras_flush (applied on any clock, independent of upd): count=0, pointer=0, ras_overflow=0. Entry contents are don't-care. Flush beats a same-cycle push or pop.
- redirect never modifies the RAS; pair it with ras_flush if required.
- Latency: pcaddr updates one cycle after the upd edge. ras_top/empty/full reflect registered state.

Test Plan:
1. Reset to RESET_PC=0x400; hold advance=1 for 3 cycles → pcaddr 0x400, 0x404, 0x408, 0x40C. Raise stall with advance=1 → pcaddr holds.
2. pcaddr=0x100, Branch, bimm=-2 (16'hFFFE): BR_REL_NPC=0 → 0xF8; BR_REL_NPC=1 → 0xFC. With advance=0 → stays 0x100.
3. pcaddr=0x1000_0040, Jump+Link, jimm=0x10: JUMP_KEEP_UPPER=1 → 0x1000_0040; JUMP_KEEP_UPPER=0 → 0x40. ras_top=0x1000_0044, ras_count=1. Next JR+Ret with jraddr=0xDEAD → pcaddr=0x1000_0044, ras_empty=1.
4. RAS_DEPTH=4: push 5 calls from pcaddr 0x0, 0x10, 0x20, 0x30, 0x40 → ras_full=1, ras_overflow=1, count=4. Pop 4 times → targets 0x44, 0x34, 0x24, 0x14. A 5th return with jraddr=0x80 → 0x80.
5. Same cycle: redirect=1 (addr 0x200) with Jump+Link → pcaddr=0x200, no push. JR+Ret+Link with 1 entry → PC=old top, new top=npc, count stays 1.
6. Assert RST mid-stream with 3 RAS entries and pcaddr=0x50 → immediately pcaddr=RESET_PC, count=0, overflow=0. ras_flush together with a push → count=0.

Source files
------------

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - fetch-stage next-PC selector with circular return-address stack
// Priority: redirect > return (RAS) > register jump > absolute jump > branch > sequential.
module pc_ras_unit #(
  parameter int          ADDR_W          = 32,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BIMM_W          = 16,
  parameter int          JIMM_W          = 26,
  parameter int          RAS_DEPTH       = 8,
  parameter int          BR_REL_NPC      = 0,
  parameter int          JUMP_KEEP_UPPER = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         advance,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_addr,
  input  logic                         Branch,
  input  logic [BIMM_W-1:0]            bimm,
  input  logic                         Jump,
  input  logic [JIMM_W-1:0]            jimm,
  input  logic                         Link,
  input  logic                         JR,
  input  logic                         Ret,
  input  logic [ADDR_W-1:0]            jraddr,
  input  logic                         ras_flush,
  output logic [ADDR_W-1:0]            pcaddr,
  output logic [ADDR_W-1:0]            npc,
  output logic [ADDR_W-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]     PTR_ONE    = PW'(1);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]     CNT_MAX    = CW'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] UPPER_MASK = {ADDR_W{1'b1}} << (JIMM_W + 2);

  logic [ADDR_W-1:0] r_pc;
  logic [PW-1:0]     r_sp;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic              w_upd, w_empty, w_full, w_pop, w_push;
  logic [PW-1:0]     w_top_idx;
  logic [ADDR_W-1:0] w_npc, w_ras_top, w_br_base, w_br_off, w_br_tgt;
  logic [ADDR_W-1:0] w_jmp_low, w_jmp_tgt, w_next_pc;

  assign w_upd     = advance & ~stall;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_MAX);
  assign w_top_idx = r_sp - PTR_ONE;
  assign w_ras_top = w_empty ? '0 : r_ras[w_top_idx];
  assign w_npc     = r_pc + ADDR_W'(4);

  // RAS side effects are suppressed by redirect; the PC still follows redirect_addr.
  assign w_pop  = w_upd & ~redirect & JR & Ret & ~w_empty;
  assign w_push = w_upd & ~redirect & Link & (Jump | JR);

  assign w_br_base = (BR_REL_NPC != 0) ? w_npc : r_pc;
  assign w_br_off  = ADDR_W'($signed(bimm));
  assign w_br_tgt  = w_br_base + (w_br_off << 2);

  assign w_jmp_low = ADDR_W'({jimm, 2'b00});
  assign w_jmp_tgt = (JUMP_KEEP_UPPER != 0) ? ((w_npc & UPPER_MASK) | w_jmp_low) : w_jmp_low;

  always_comb begin
    w_next_pc = w_npc;
    if (redirect)                   w_next_pc = redirect_addr;
    else if (JR && Ret && !w_empty) w_next_pc = w_ras_top;
    else if (JR)                    w_next_pc = jraddr;
    else if (Jump)                  w_next_pc = w_jmp_tgt;
    else if (Branch)                w_next_pc = w_br_tgt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (w_upd) begin
      r_pc <= w_next_pc;
    end
  end

  // Simultaneous push and pop collapse into an in-place replacement of the top entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (ras_flush) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_push && w_pop) begin
      r_ras[w_top_idx] <= w_npc;
    end else if (w_push) begin
      r_ras[r_sp] <= w_npc;
      r_sp        <= r_sp + PTR_ONE;
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + CNT_ONE;
    end else if (w_pop) begin
      r_sp  <= w_top_idx;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign pcaddr       = r_pc;
  assign npc          = w_npc;
  assign ras_top      = w_ras_top;
  assign ras_count    = r_cnt;
  assign ras_empty    = w_empty;
  assign ras_full     = w_full;
  assign ras_overflow = r_ovf;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb/tb_pc_ras_unit.sv - directed bench for pc_ras_unit (two parameter sets, shared stimulus)
// Instance a: depth 4, pcaddr-relative branch, zeroed jump upper; instance b: depth 8, npc-relative, kept upper.
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance, stall, redirect, branch, jump, link, jr, ret, ras_flush;
  logic [31:0] redirect_addr, jraddr;
  logic [15:0] bimm;
  logic [25:0] jimm;

  logic [31:0] a_pc, a_npc, a_top, b_pc, b_npc, b_top;
  logic [2:0]  a_cnt;
  logic [3:0]  b_cnt;
  logic        a_empty, a_full, a_ovf, b_empty, b_full, b_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ras_unit #(.ADDR_W(32), .RESET_PC(32'h400), .BIMM_W(16), .JIMM_W(26), .RAS_DEPTH(4),
                .BR_REL_NPC(0), .JUMP_KEEP_UPPER(0)) u_a (
    .CLK(clk), .RST(rst), .advance(advance), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .Branch(branch), .bimm(bimm), .Jump(jump), .jimm(jimm),
    .Link(link), .JR(jr), .Ret(ret), .jraddr(jraddr), .ras_flush(ras_flush),
    .pcaddr(a_pc), .npc(a_npc), .ras_top(a_top), .ras_count(a_cnt), .ras_empty(a_empty),
    .ras_full(a_full), .ras_overflow(a_ovf));

  pc_ras_unit #(.ADDR_W(32), .RESET_PC(32'h400), .BIMM_W(16), .JIMM_W(26), .RAS_DEPTH(8),
                .BR_REL_NPC(1), .JUMP_KEEP_UPPER(1)) u_b (
    .CLK(clk), .RST(rst), .advance(advance), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .Branch(branch), .bimm(bimm), .Jump(jump), .jimm(jimm),
    .Link(link), .JR(jr), .Ret(ret), .jraddr(jraddr), .ras_flush(ras_flush),
    .pcaddr(b_pc), .npc(b_npc), .ras_top(b_top), .ras_count(b_cnt), .ras_empty(b_empty),
    .ras_full(b_full), .ras_overflow(b_ovf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; redirect = 0; branch = 0; jump = 0; link = 0; jr = 0; ret = 0; ras_flush = 0;
  endtask

  task automatic go_to(input logic [31:0] addr);
    clear_ctrl();
    redirect = 1; redirect_addr = addr;
    step();
    redirect = 0;
  endtask

  initial begin
    rst = 1; advance = 0; redirect_addr = 0; jraddr = 0; bimm = 0; jimm = 0;
    clear_ctrl();
    #2;
    check("reset_pc_a", a_pc, 32'h400);
    check("reset_pc_b", b_pc, 32'h400);
    check("reset_cnt_a", 32'(a_cnt), 0);
    check("reset_empty_a", 32'(a_empty), 1);
    check("reset_ovf_a", 32'(a_ovf), 0);
    check("reset_top_a", a_top, 0);
    @(negedge clk);
    rst = 0;

    // Sequential fetch and stall
    advance = 1;
    step(); check("seq1", a_pc, 32'h404);
    step(); check("seq2", a_pc, 32'h408);
    step(); check("seq3_a", a_pc, 32'h40C);
    check("seq3_b", b_pc, 32'h40C);
    check("npc_comb", a_npc, 32'h410);
    stall = 1;
    step(); check("stall_hold", a_pc, 32'h40C);
    stall = 0;

    // Branch backward by two words
    go_to(32'h100);
    check("redir_100", a_pc, 32'h100);
    branch = 1; bimm = 16'hFFFE; advance = 0;
    step(); check("br_noadv", a_pc, 32'h100);
    advance = 1;
    step();
    check("br_rel_pc", a_pc, 32'hF8);
    check("br_rel_npc", b_pc, 32'hFC);
    branch = 0;

    // Call and return
    go_to(32'h1000_0040);
    jump = 1; link = 1; jimm = 26'h10;
    step();
    check("jmp_zero_upper", a_pc, 32'h40);
    check("jmp_keep_upper", b_pc, 32'h1000_0040);
    check("call_top_a", a_top, 32'h1000_0044);
    check("call_top_b", b_top, 32'h1000_0044);
    check("call_cnt_a", 32'(a_cnt), 1);
    clear_ctrl();
    jr = 1; ret = 1; jraddr = 32'hDEAD;
    step();
    check("ret_pc_a", a_pc, 32'h1000_0044);
    check("ret_pc_b", b_pc, 32'h1000_0044);
    check("ret_empty_a", 32'(a_empty), 1);

    // Overflow a depth-4 stack with five calls
    for (int k = 0; k < 5; k++) begin
      go_to(32'(k * 16));
      jump = 1; link = 1; jimm = 0;
      step();
    end
    clear_ctrl();
    check("ovf_full_a", 32'(a_full), 1);
    check("ovf_flag_a", 32'(a_ovf), 1);
    check("ovf_cnt_a", 32'(a_cnt), 4);
    check("ovf_cnt_b", 32'(b_cnt), 5);
    check("ovf_flag_b", 32'(b_ovf), 0);
    jr = 1; ret = 1; jraddr = 32'h80;
    step(); check("pop1", a_pc, 32'h44);
    step(); check("pop2", a_pc, 32'h34);
    step(); check("pop3", a_pc, 32'h24);
    step(); check("pop4", a_pc, 32'h14);
    step();
    check("pop_empty_a", a_pc, 32'h80);
    check("pop5_b", b_pc, 32'h04);
    clear_ctrl();

    // Redirect suppresses the push
    redirect = 1; redirect_addr = 32'h200; jump = 1; link = 1; jimm = 26'h3;
    step();
    check("redir_pc", a_pc, 32'h200);
    check("redir_nopush", 32'(a_cnt), 0);
    clear_ctrl();
    jump = 1; link = 1; jimm = 26'h100;
    step();
    check("call2_pc", a_pc, 32'h400);
    check("call2_top", a_top, 32'h204);
    clear_ctrl();
    jr = 1; ret = 1; link = 1; jraddr = 32'h999;
    step();
    check("pushpop_pc", a_pc, 32'h204);
    check("pushpop_top", a_top, 32'h404);
    check("pushpop_cnt", 32'(a_cnt), 1);
    clear_ctrl();

    // Build three entries, then asynchronous reset mid-cycle
    jump = 1; link = 1; jimm = 26'h14;
    step();
    clear_ctrl();
    jr = 1; link = 1; jraddr = 32'h50;
    step();
    clear_ctrl();
    check("pre_rst_cnt", 32'(a_cnt), 3);
    check("pre_rst_pc", a_pc, 32'h50);
    check("pre_rst_ovf", 32'(a_ovf), 1);
    #2 rst = 1;
    #1;
    check("async_rst_pc", a_pc, 32'h400);
    check("async_rst_cnt", 32'(a_cnt), 0);
    check("async_rst_ovf", 32'(a_ovf), 0);
    @(negedge clk);
    rst = 0;

    // Flush wins over a same-cycle push
    jump = 1; link = 1; jimm = 0;
    step();
    check("pre_flush_cnt", 32'(a_cnt), 1);
    ras_flush = 1;
    step();
    check("flush_cnt_a", 32'(a_cnt), 0);
    check("flush_cnt_b", 32'(b_cnt), 0);
    check("flush_jump_pc", a_pc, 32'h0);
    clear_ctrl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
